// File: rtl/legv8_ts_bus_arbiter_if.sv
// legv8_ts_bus_arbiter_if: request/grant and memory-strobe bundle for the tristate bus arbiter
interface legv8_ts_bus_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int N_CH   = 2
);
  logic [N_CH-1:0]        req;
  logic [N_CH-1:0]        we;
  logic [N_CH*ADDR_W-1:0] addr_in;
  logic [N_CH*DATA_W-1:0] wdata_in;
  logic [N_CH-1:0]        grant;
  logic [N_CH-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;
  logic [ADDR_W-1:0]      address;
  logic                   mem_we;
  logic                   mem_oe;
  modport slave (
    input  req, we, addr_in, wdata_in,
    output grant, ack, rdata, busy, address, mem_we, mem_oe
  );
  modport master (
    output req, we, addr_in, wdata_in,
    input  grant, ack, rdata, busy, address, mem_we, mem_oe
  );
endinterface

// File: rtl/legv8_ts_bus_arbiter.sv
// legv8_ts_bus_arbiter: N-channel sequencer for the shared tristate memory bus; define LEGv8_TS_RR_EN for round-robin
module legv8_ts_bus_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 32,
  parameter int N_CH     = 2,
  parameter int WAIT_CYC = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  legv8_ts_bus_arbiter_if.slave bus,
  inout  wire  [DATA_W-1:0]     data
);
  localparam int CW = WAIT_CYC > 0 ? $clog2(WAIT_CYC + 1) : 1;
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int NP = 2 ** IW;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [IW-1:0]     idx, idx_d, win;
  logic [N_CH-1:0]   oh_d;
  logic [NP-1:0]     req_x, we_x;
  logic              we_q, we_d, take, drive;
  logic [DATA_W-1:0] wdata_q;
  assign req_x = NP'(bus.req);
  assign we_x  = NP'(bus.we);
`ifdef LEGv8_TS_RR_EN
  logic [IW-1:0] ptr;
  logic [IW:0]   c;
  // walk from farthest to nearest so the channel right after ptr wins last
  always_comb begin
    win = ptr;
    c = '0;
    for (int i = N_CH; i >= 1; i--) begin
      c = {1'b0, ptr} + (IW+1)'(i);
      c = c >= (IW+1)'(N_CH) ? c - (IW+1)'(N_CH) : c;
      win = req_x[c[IW-1:0]] ? c[IW-1:0] : win;
    end
  end
  always_ff @(posedge clock)
    if (!reset) ptr <= IW'(N_CH - 1);
    else if (take) ptr <= win;
`else
  always_comb begin
    win = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      win = req_x[i] ? IW'(i) : win;
  end
`endif
  always_comb begin
    take = state == IDLE && |bus.req;
    idx_d = take ? win : idx;
    we_d = take ? we_x[win] : we_q;
    oh_d = N_CH'(1) << idx_d;
    state_d = state == IDLE   ? (take ? SETUP : IDLE) :
              state == SETUP  ? ACCESS :
              state == ACCESS ? (cnt == '0 ? DONE : ACCESS) : IDLE;
    cnt_d = state == SETUP ? CW'(WAIT_CYC) :
            state == ACCESS && cnt != '0 ? cnt - CW'(1) : cnt;
  end
  // outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      drive       <= 1'b0;
      bus.grant   <= '0;
      bus.ack     <= '0;
      bus.rdata   <= '0;
      bus.busy    <= 1'b0;
      bus.address <= '0;
      bus.mem_we  <= 1'b0;
      bus.mem_oe  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      we_q  <= we_d;
      if (take) begin
        bus.address <= bus.addr_in[win*ADDR_W +: ADDR_W];
        wdata_q     <= bus.wdata_in[win*DATA_W +: DATA_W];
      end
      if (state == ACCESS && cnt == '0 && !we_q) bus.rdata <= data;
      bus.busy   <= state_d != IDLE;
      bus.grant  <= state_d != IDLE ? oh_d : '0;
      bus.ack    <= state_d == DONE ? oh_d : '0;
      bus.mem_oe <= !we_d && (state_d == SETUP || state_d == ACCESS);
      bus.mem_we <= we_d && state_d == ACCESS;
      drive      <= we_d && (state_d == SETUP || state_d == ACCESS);
    end
  end
  assign data = drive ? wdata_q : 'z;
endmodule

// File: tb/tb_legv8_ts_bus_arbiter.sv
// tb_legv8_ts_bus_arbiter: vector table plus ack scoreboard for the 2-channel build, and a 1-channel zero-wait build
module tb_legv8_ts_bus_arbiter;
  localparam int W = 1;
  localparam logic [63:0] ONES = '1;
  typedef struct {int ch; logic w; logic [31:0] a; logic [63:0] d; logic [63:0] e;} vec_t;
  typedef struct {int ch; logic rd; logic [63:0] rdata;} exp_t;
  logic clock = 0, reset = 0;
  int total = 0, bad = 0;
  exp_t exp_q[$];
  logic [63:0] mem [16];
  logic [63:0] last_rd;
  vec_t vecs[8];
  int arb_exp[4];
  int cyc, prev;
  tri1 [63:0] data;
  tri1 [63:0] data1;
  legv8_ts_bus_arbiter_if #(.DATA_W(64), .ADDR_W(32), .N_CH(2)) bus ();
  legv8_ts_bus_arbiter_if #(.DATA_W(64), .ADDR_W(32), .N_CH(1)) bus1 ();
  legv8_ts_bus_arbiter #(.DATA_W(64), .ADDR_W(32), .N_CH(2), .WAIT_CYC(W)) dut (
    .clock(clock), .reset(reset), .bus(bus), .data(data));
  legv8_ts_bus_arbiter #(.DATA_W(64), .ADDR_W(32), .N_CH(1), .WAIT_CYC(0)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .data(data1));
  always #5 clock = ~clock;
  assign data  = bus.mem_oe ? mem[bus.address[7:4]] : 'z;
  assign data1 = bus1.mem_oe ? (64'hA5A5_0000_1234_5678 ^ {32'h0, bus1.address}) : 'z;
  always @(posedge clock) if (bus.mem_we) mem[bus.address[7:4]] <= data;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  always @(negedge clock) begin
    if (bus.ack != '0) begin
      if (exp_q.size() == 0) chk("unexpected_ack", 64'(bus.ack), 64'h0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_ack", 64'(bus.ack), 64'(2'b01 << e.ch));
        if (e.rd) chk("sb_rdata", bus.rdata, e.rdata);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clock);
    while (bus.busy && t < 30) begin
      @(negedge clock);
      t++;
    end
    chk("idle_timeout", 64'(bus.busy), 64'h0);
  endtask

  task automatic drive_req(input int ch, input logic w, input logic [31:0] a, input logic [63:0] d);
    bus.req = '0;
    bus.req[ch] = 1'b1;
    bus.we[ch] = w;
    bus.addr_in[ch*32 +: 32] = a;
    bus.wdata_in[ch*64 +: 64] = d;
  endtask

  task automatic txn(input int ch, input logic w, input logic [31:0] a, input logic [63:0] d, input logic [63:0] e);
    logic [1:0] oh;
    oh = 2'b01 << ch;
    wait_idle();
    drive_req(ch, w, a, d);
    exp_q.push_back('{ch, !w, e});
    for (int k = 1; k <= 3 + W; k++) begin
      @(negedge clock);
      chk("grant", 64'(bus.grant), 64'(oh));
      chk("address", 64'(bus.address), 64'(a));
      chk("strobes", 64'({bus.mem_oe, bus.mem_we, bus.busy}),
          64'({!w && k <= 2 + W, w && k >= 2 && k <= 2 + W, 1'b1}));
      chk("data_bus", data, k <= 2 + W ? (w ? d : e) : ONES);
      chk("ack_timing", 64'(bus.ack), k == 3 + W ? 64'(oh) : 64'h0);
    end
    bus.req = '0;
    if (w) chk("rdata_hold", bus.rdata, last_rd);
    else last_rd = e;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {32'hDEAD_BEEF, i};
    vecs[0] = '{0, 1'b0, 32'h10, 64'h0, 64'hDEAD_BEEF_0000_0001};
    vecs[1] = '{1, 1'b1, 32'h20, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[2] = '{0, 1'b0, 32'h20, 64'h0, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{0, 1'b1, 32'h30, 64'hCAFE_F00D_0000_0030, 64'h0};
    vecs[4] = '{1, 1'b0, 32'h30, 64'h0, 64'hCAFE_F00D_0000_0030};
    vecs[5] = '{1, 1'b0, 32'h50, 64'h0, 64'hDEAD_BEEF_0000_0005};
    vecs[6] = '{1, 1'b1, 32'h10, 64'h1111_2222_3333_4444, 64'h0};
    vecs[7] = '{0, 1'b0, 32'h10, 64'h0, 64'h1111_2222_3333_4444};
`ifdef LEGv8_TS_RR_EN
    arb_exp = '{0, 1, 0, 1};
`else
    arb_exp = '{0, 0, 0, 0};
`endif
    bus.req = '0; bus.we = '0; bus.addr_in = '0; bus.wdata_in = '0;
    bus1.req = '0; bus1.we = '0; bus1.addr_in = '0; bus1.wdata_in = '0;
    last_rd = '0;
    repeat (2) @(negedge clock);
    chk("rst_grant", 64'(bus.grant), 64'h0);
    chk("rst_ack", 64'(bus.ack), 64'h0);
    chk("rst_rdata", bus.rdata, 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_address", 64'(bus.address), 64'h0);
    chk("rst_strobes", 64'({bus.mem_we, bus.mem_oe}), 64'h0);
    chk("rst_data", data, ONES);
    chk("rst1_outs", 64'({bus1.grant, bus1.ack, bus1.busy, bus1.mem_we, bus1.mem_oe}), 64'h0);
    chk("rst1_rdata", bus1.rdata, 64'h0);
    chk("rst1_data", data1, ONES);
    reset = 1;
    for (int i = 0; i < 8; i++) txn(vecs[i].ch, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].e);
    // req dropped mid-ACCESS: the read still completes with exactly one ack
    wait_idle();
    drive_req(0, 1'b0, 32'h20, 64'h0);
    exp_q.push_back('{0, 1'b1, 64'h0123_4567_89AB_CDEF});
    repeat (2) @(negedge clock);
    bus.req = '0;
    repeat (2) @(negedge clock);
    chk("drop_ack", 64'(bus.ack), 64'h1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("drop_idle", 64'(bus.busy), 64'h0);
    end
    // reset during the ACCESS of a write releases the bus with no ack
    wait_idle();
    drive_req(0, 1'b1, 32'h40, 64'h7777_8888_9999_AAAA);
    repeat (2) @(negedge clock);
    chk("abort_pre_we", 64'(bus.mem_we), 64'h1);
    chk("abort_pre_data", data, 64'h7777_8888_9999_AAAA);
    reset = 0;
    bus.req = '0;
    @(negedge clock);
    chk("abort_data", data, ONES);
    chk("abort_outs", 64'({bus.mem_we, bus.mem_oe, bus.busy, bus.grant, bus.ack}), 64'h0);
    chk("abort_rdata", bus.rdata, 64'h0);
    reset = 1;
    last_rd = '0;
    txn(1, 1'b0, 32'h30, 64'h0, 64'hCAFE_F00D_0000_0030);
    // both channels requesting continuously
    wait_idle();
    bus.we = '0;
    bus.addr_in = {32'h20, 32'h10};
    bus.req = 2'b11;
    for (int n = 0; n < 4; n++)
      exp_q.push_back('{arb_exp[n], 1'b1,
                        arb_exp[n] == 0 ? 64'h1111_2222_3333_4444 : 64'h0123_4567_89AB_CDEF});
    cyc = 0;
    prev = 0;
    for (int n = 0; n < 4; n++) begin
      int t;
      t = 0;
      do begin
        @(negedge clock);
        cyc++;
        t++;
      end while (bus.ack == '0 && t < 20);
      chk("arb_owner", 64'(bus.ack), 64'(2'b01 << arb_exp[n]));
      if (n > 0) chk("arb_spacing", 64'(cyc - prev), 64'(W + 4));
      else chk("arb_first", 64'(cyc), 64'(3 + W));
      prev = cyc;
    end
    bus.req = '0;
    wait_idle();
    // single-channel zero-wait build: ack in cycle 3, back-to-back every 4 cycles
    bus1.addr_in = 32'h8;
    bus1.req = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clock);
      chk("d1_ack", 64'(bus1.ack), 64'(k % 4 == 3 && k < 12));
      chk("d1_grant", 64'(bus1.grant), 64'(k % 4 != 0 && k < 12));
      chk("d1_busy", 64'(bus1.busy), 64'(k % 4 != 0 && k < 12));
      if (k % 4 == 3) chk("d1_rdata", bus1.rdata, 64'hA5A5_0000_1234_5670);
      if (k == 11) bus1.req = 1'b0;
    end
    chk("sb_drain", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/legv8_ts_bus_arbiter.md
# legv8_ts_bus_arbiter

Parametrised N-channel arbiter and sequencer for the shared tristate memory bus of the LEGv8 CPU. It sits between up to N_CH bus masters (CPU datapath, instruction fetch, debug/DMA port) and the single bidirectional `data` / `address` memory bus. It serialises their requests into fixed-shape read/write cycles with configurable wait states. It owns the only tristate driver on `data`, so no two requesters can ever contend for the bus.

## Interface
- DATA_W, 64, data bus width
- ADDR_W, 32, address width
- N_CH, 2, number of requesting channels (1..8)
- WAIT_CYC, 1, extra ACCESS cycles per transaction (0..15)

- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; sampled on rising `clock`
- req  in  N_CH  per-channel request, held until `ack`
- we  in  N_CH  per-channel write enable (1 = write)
- addr_in  in  N_CH*ADDR_W  channel c address at [c*ADDR_W +: ADDR_W]
- wdata_in  in  N_CH*DATA_W  channel c write data at [c*DATA_W +: DATA_W]
- grant  out  N_CH  one-hot owner of the current transaction
- ack  out  N_CH  one-cycle completion pulse to the owner
- rdata  out  DATA_W  read data, valid while `ack` is high on a read
- busy  out  1  high in any state other than IDLE
- address  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_oe  out  1  memory output enable (read)
- data  inout  DATA_W  shared memory data bus

## Operation
- FSM states: IDLE → SETUP → ACCESS → DONE → IDLE.
- IDLE: if any `req` bit is set, select a winner (see Configuration). Latch its index, `we`, address and write data. Go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle):
  - `grant` is one-hot on the winner; `address` shows the latched address.
  - Read: `mem_oe`=1.
  - Write: `data` is driven with the latched write data; `mem_we` stays 0.
  - Load the wait counter with WAIT_CYC.
- ACCESS (WAIT_CYC+1 cycles): `address` and `grant` hold.
  - Read: `mem_oe`=1.
  - Write: `data` is driven and `mem_we`=1.
  - Decrement the counter each cycle. When it is 0, a read captures `data` into `rdata`, then the FSM goes to DONE.
- DONE (1 cycle): `ack[winner]`=1 and `grant` holds. `mem_we`=0, `mem_oe`=0, `data`=Z. Next state is IDLE. DONE plus IDLE form the bus turnaround gap.
- `data` is driven only in SETUP and ACCESS of a write transaction; it is Z at all other times.
- `req`, `we`, `addr_in` and `wdata_in` are ignored outside IDLE. Dropping `req` mid-transaction does not abort it: the transaction completes and `ack` still pulses.
- A requester must drop `req` on the edge at which it sees `ack`. If `req` is still high in the following IDLE cycle, it is a new request.
- `rdata` holds its value until the next read completes.
- N_CH=1: arbitration is trivial, with `grant`[0] asserted on every transaction.

## Timing
- Reset (`reset`=0 at an edge) forces IDLE in any state. After that edge:
  - `grant`=0, `ack`=0, `rdata`=0, `busy`=0, `address`=0, `mem_we`=0, `mem_oe`=0, `data`=Z.
  - The round-robin pointer is reset to N_CH-1, so channel 0 has first priority.
- Reset in mid-transaction releases the bus on that edge and produces no `ack`.
- With `req` sampled high in IDLE at edge 0:
  - SETUP occupies cycle 1.
  - ACCESS occupies cycles 2..2+WAIT_CYC.
  - `ack` is high in cycle 3+WAIT_CYC.
- Minimum spacing between transactions is WAIT_CYC+4 cycles (next SETUP at 5+WAIT_CYC).
- Read data is sampled on the final ACCESS edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The wait counter width is max(1, clog2(WAIT_CYC+1)) bits.

## Configuration
- `LEGv8_TS_RR_EN` defined: round-robin arbitration. The search starts at (last_winner+1) mod N_CH, and the pointer updates on each IDLE→SETUP transition.
- `LEGv8_TS_RR_EN` undefined: fixed priority, lowest index wins. No pointer register exists.

## Test plan
- Single read, WAIT_CYC=1, ch0 at 0x0000_0010 with memory returning 0xDEAD_BEEF_0000_0001 → `ack`[0] high in cycle 4, `rdata`=0xDEAD_BEEF_0000_0001, `data` never driven by the DUT.
- Single write, ch1 writing 0x0123_4567_89AB_CDEF to 0x20 → `data` driven in cycles 1..2+WAIT_CYC, `mem_we`=1 in ACCESS only, `data`=Z in the DONE cycle.
- Both channels requesting continuously with RR_EN defined → grants alternate 0,1,0,1. With it undefined → ch0 is granted every time and ch1 starves.
- `req`[0] dropped during ACCESS → the transaction completes, `ack`[0] pulses once, and no second transaction starts.
- `reset`=0 asserted during the ACCESS of a write → on the next edge `data`=Z, `mem_we`=0, `busy`=0, no `ack`. A post-reset request from ch1 then proceeds normally.
- WAIT_CYC=0 and N_CH=1 build → read `ack` arrives in cycle 3, and back-to-back requests are spaced 4 cycles apart.
